// File: rtl/auto_player_pkg.sv
// Shared types and constants for the auto_player_gen AI paddle controller:
// FSM states, approach-mode encodings, LFSR taps and the difficulty mask.
package auto_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REACT = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    localparam logic [1:0] MODE_XH   = 2'd0;
    localparam logic [1:0] MODE_WALL = 2'd1;
    localparam logic [1:0] MODE_TURN = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    // Feedback taps l[15]^l[13]^l[12]^l[10].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Easier levels let more LFSR bits through, giving a larger aim error.
    function automatic logic [15:0] level_mask(input logic [1:0] level, input int err_w);
        int nbits;
        case (level)
            2'd0:    nbits = 0;
            2'd1:    nbits = err_w - 2;
            2'd2:    nbits = err_w - 1;
            default: nbits = err_w;
        endcase
        level_mask = 16'((17'd1 << nbits) - 17'd1);
    endfunction

endpackage

// File: rtl/auto_player_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left, advancing one step when step_i is high.
module lfsr16
    import auto_player_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/auto_player_gen.sv
// AI paddle controller: waits for the ball to approach, adds a level-dependent
// aim error and reaction delay, then steers with registered active-low p/m requests.
module auto_player_gen
    import auto_player_pkg::*;
#(
    parameter int          CW            = 10,
    parameter int          ERR_W         = 6,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          REACT_STEP    = 4,
    parameter int          DEADBAND      = 2,
    parameter int          CENTER        = 240,
    parameter bit          RETURN_CENTER = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          turn,
    input  logic          hit,
    input  logic          wall,
    input  logic          start_state,
    input  logic          xh,
    input  logic [1:0]    mode,
    input  logic [1:0]    level,
    input  logic [CW-1:0] by,
    input  logic [CW-1:0] py,
    output logic          p,
    output logic          m,
    output logic          busy
);

    localparam int XW = CW + 1;
    localparam int DW = (3 * REACT_STEP + 1 > 2) ? $clog2(3 * REACT_STEP + 1) : 1;
    localparam logic [XW-1:0] DB_X     = XW'(DEADBAND);
    localparam logic [XW-1:0] CENTER_X = XW'(CENTER);
    localparam logic [XW-1:0] TGT_MAX  = {1'b0, {CW{1'b1}}};

    state_e        state_q, state_d;
    logic [DW-1:0] delay_q, delay_d, delay_load;
    logic [ERR_W-1:0] err_mag_q, err_mag_d;
    logic          err_neg_q, err_neg_d;
    logic          wall_lat_q, wall_lat_d;
    logic          p_q, p_d, m_q, m_d;

    logic          approach;
    logic          lfsr_step;
    logic [15:0]   lfsr;
    logic [15:0]   mask_full;
    logic [XW-1:0] by_x, py_x, err_x, sum_x, diff_x, target_x;
    logic [1:0]    track_move, center_move;
    logic          unused_bits;

    // Returns {p, m}: active-low request toward tgt, idle inside the deadband.
    function automatic logic [1:0] steer(input logic [XW-1:0] pos, input logic [XW-1:0] tgt);
        if (pos + DB_X < tgt) begin
            steer = 2'b01;
        end else if (pos > tgt + DB_X) begin
            steer = 2'b10;
        end else begin
            steer = 2'b11;
        end
    endfunction

    assign lfsr_step = en & (hit | ((mode == MODE_TURN) & wall));

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_i  (lfsr_step),
        .value_o (lfsr)
    );

    assign mask_full   = level_mask(level, ERR_W);
    assign delay_load  = DW'(level * REACT_STEP);
    assign unused_bits = ^{lfsr[14:ERR_W], mask_full[15:ERR_W]};

    always_comb begin
        case (mode)
            MODE_XH:   approach = xh;
            MODE_WALL: approach = wall_lat_q;
            MODE_TURN: approach = turn;
            default:   approach = 1'b0;
        endcase
    end

    // Signed aim offset applied at CW+1 bits, clamped to the playfield.
    assign by_x   = {1'b0, by};
    assign py_x   = {1'b0, py};
    assign err_x  = {{(XW - ERR_W){1'b0}}, err_mag_q};
    assign sum_x  = by_x + err_x;
    assign diff_x = by_x - err_x;

    always_comb begin
        if (err_neg_q) begin
            target_x = diff_x[CW] ? '0 : diff_x;
        end else begin
            target_x = sum_x[CW] ? TGT_MAX : sum_x;
        end
    end

    assign track_move  = steer(py_x, target_x);
    assign center_move = steer(py_x, CENTER_X);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        err_mag_d  = err_mag_q;
        err_neg_d  = err_neg_q;
        wall_lat_d = wall_lat_q;
        p_d        = 1'b1;
        m_d        = 1'b1;

        if (en) begin
            if (wall) begin
                wall_lat_d = 1'b1;
            end else if (start_state) begin
                wall_lat_d = 1'b0;
            end

            if (start_state) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (RETURN_CENTER) begin
                            {p_d, m_d} = center_move;
                        end
                        if (approach) begin
                            err_mag_d = lfsr[ERR_W-1:0] & mask_full[ERR_W-1:0];
                            err_neg_d = lfsr[15];
                            delay_d   = delay_load;
                            state_d   = (delay_load == '0) ? ST_TRACK : ST_REACT;
                        end
                    end
                    ST_REACT: begin
                        if (!approach) begin
                            state_d = ST_IDLE;
                        end else begin
                            delay_d = delay_q - DW'(1);
                            if (delay_q == DW'(1)) begin
                                state_d = ST_TRACK;
                            end
                        end
                    end
                    ST_TRACK: begin
                        {p_d, m_d} = track_move;
                        if (!approach) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            err_mag_q  <= '0;
            err_neg_q  <= 1'b0;
            wall_lat_q <= 1'b0;
            p_q        <= 1'b1;
            m_q        <= 1'b1;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            err_mag_q  <= err_mag_d;
            err_neg_q  <= err_neg_d;
            wall_lat_q <= wall_lat_d;
            p_q        <= p_d;
            m_q        <= m_d;
        end
    end

    assign p    = p_q;
    assign m    = m_q;
    assign busy = (state_q == ST_REACT) || (state_q == ST_TRACK);

endmodule

// File: tb/tb_auto_player_gen.sv
// Scoreboard bench for auto_player_gen: a behavioural game-AI model predicts
// {p, m, busy} per cycle and a monitor compares after each rising edge.
module tb_auto_player_gen;

    localparam int CW            = 10;
    localparam int ERR_W         = 6;
    localparam int REACT_STEP    = 4;
    localparam int DEADBAND      = 2;
    localparam int CENTER        = 240;
    localparam bit RETURN_CENTER = 1'b1;
    localparam int Y_MAX         = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, turn, hit, wall, start_state, xh;
    logic [1:0]    mode, level;
    logic [CW-1:0] by, py;
    logic          p, m, busy;

    auto_player_gen #(
        .CW            (CW),
        .ERR_W         (ERR_W),
        .LFSR_SEED     (16'hACE1),
        .REACT_STEP    (REACT_STEP),
        .DEADBAND      (DEADBAND),
        .CENTER        (CENTER),
        .RETURN_CENTER (RETURN_CENTER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .turn        (turn),
        .hit         (hit),
        .wall        (wall),
        .start_state (start_state),
        .xh          (xh),
        .mode        (mode),
        .level       (level),
        .by          (by),
        .py          (py),
        .p           (p),
        .m           (m),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic p;
        logic m;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: what the AI is doing, how many cycles it still hesitates,
    // its signed aim offset, the random generator and the remembered wall bounce.
    typedef enum {M_IDLE, M_WAIT, M_CHASE} phase_e;
    phase_e ph;
    int     wait_left;
    int     offset;
    int     lf;
    bit     wl;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: p/m/busy got %b, expected %b at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [1:0] want_pm(input int pos, input int tgt);
        if (pos + DEADBAND < tgt) return 2'b01;
        if (pos > tgt + DEADBAND) return 2'b10;
        return 2'b11;
    endfunction

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) & 16'hFFFF) | fb;
    endfunction

    task automatic model_reset();
        ph        = M_IDLE;
        wait_left = 0;
        offset    = 0;
        lf        = 16'hACE1;
        wl        = 1'b0;
    endtask

    task automatic model_step(output exp_t e);
        logic [1:0] pm;
        bit         appr;
        int         t;
        int         bits;
        pm = 2'b11;
        if (en) begin
            case (mode)
                2'd0:    appr = xh;
                2'd1:    appr = wl;
                2'd2:    appr = turn;
                default: appr = 1'b0;
            endcase
            if (!start_state) begin
                if (ph == M_CHASE) begin
                    t = int'(by) + offset;
                    if (t < 0) t = 0;
                    if (t > Y_MAX) t = Y_MAX;
                    pm = want_pm(int'(py), t);
                end else if (ph == M_IDLE && RETURN_CENTER) begin
                    pm = want_pm(int'(py), CENTER);
                end
            end
            if (start_state) begin
                ph = M_IDLE;
            end else begin
                case (ph)
                    M_IDLE: if (appr) begin
                        bits      = (level == 2'd0) ? 0 : ERR_W - 3 + int'(level);
                        offset    = lf & ((1 << bits) - 1);
                        if (lf >= 32768) offset = -offset;
                        wait_left = int'(level) * REACT_STEP;
                        ph        = (wait_left == 0) ? M_CHASE : M_WAIT;
                    end
                    M_WAIT: if (!appr) begin
                        ph = M_IDLE;
                    end else begin
                        wait_left--;
                        if (wait_left == 0) ph = M_CHASE;
                    end
                    default: if (!appr) ph = M_IDLE;
                endcase
            end
            if (hit || (mode == 2'd2 && wall)) lf = lfsr_next(lf);
            if (wall) wl = 1'b1;
            else if (start_state) wl = 1'b0;
        end
        e.p    = pm[1];
        e.m    = pm[0];
        e.busy = (ph != M_IDLE);
    endtask

    // Called at a falling edge with inputs already set; predicts the next edge.
    task automatic tick();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet();
        en = 1'b1; turn = 1'b0; hit = 1'b0; wall = 1'b0; start_state = 1'b0; xh = 1'b0;
        mode = 2'd0; level = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("async_reset", {p, m, busy}, 3'b110);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {p, m, busy}, {e.p, e.m, e.busy});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int yy;
        rst = 1'b1;
        quiet();
        by = CW'(200);
        py = CW'(100);
        model_reset();
        #3;
        check("reset", {p, m, busy}, 3'b110);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hard level, mode 0: straight into tracking, chase upward.
        xh = 1'b1;
        ticks(4);
        xh = 1'b0;
        ticks(2);

        // Level 2 on turn: eight hesitation cycles, with en dropped mid-count.
        mode = 2'd2; level = 2'd2; by = CW'(500); py = CW'(480);
        turn = 1'b1;
        ticks(3);
        en = 1'b0;
        ticks(3);
        en = 1'b1;
        ticks(8);
        turn = 1'b0;
        ticks(2);

        // Asynchronous reset while tracking.
        quiet();
        xh = 1'b1; by = CW'(700); py = CW'(600);
        ticks(3);
        do_reset();

        // One hit from reset, then level 3 approach: small positive error.
        quiet();
        by = CW'(100); py = CW'(103);
        hit = 1'b1;
        tick();
        hit = 1'b0; level = 2'd3; xh = 1'b1;
        ticks(3 * REACT_STEP + 4);
        quiet();
        tick();

        // Saturation near the top wall with a range of error draws.
        for (int k = 0; k < 6; k++) begin
            quiet();
            by = CW'(1020); py = CW'(1000);
            hit = 1'b1;
            ticks(k + 1);
            hit = 1'b0; level = 2'd3; xh = 1'b1;
            ticks(3 * REACT_STEP + 3);
            py = CW'(1019);
            ticks(2);
            start_state = 1'b1;
            tick();
        end

        // Mode 1: wall beats start_state, then start_state alone clears it.
        quiet();
        mode = 2'd1; by = CW'(50); py = CW'(300);
        wall = 1'b1; start_state = 1'b1;
        tick();
        wall = 1'b0; start_state = 1'b0;
        ticks(3);
        start_state = 1'b1;
        tick();
        start_state = 1'b0;
        ticks(3);

        // Parking at centre from above, then mode 3 never engages.
        quiet();
        for (int y = 300; y >= 234; y -= 3) begin
            py = CW'(y);
            tick();
        end
        mode = 2'd3; xh = 1'b1; turn = 1'b1; wall = 1'b1;
        ticks(4);

        // Randomised play.
        quiet();
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            start_state = ($urandom_range(0, 39) == 0);
            hit         = ($urandom_range(0, 7) == 0);
            wall        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) xh = ~xh;
            if ($urandom_range(0, 9) == 0) turn = ~turn;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) level = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: by = CW'($urandom_range(0, Y_MAX));
                1: by = CW'($urandom_range(Y_MAX - 20, Y_MAX));
                2: by = CW'($urandom_range(0, 20));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                yy = CENTER - 8 + int'($urandom_range(0, 16));
            end else begin
                yy = int'(by) - 40 + int'($urandom_range(0, 80));
            end
            if (yy < 0) yy = 0;
            if (yy > Y_MAX) yy = Y_MAX;
            py = CW'(yy);
            tick();
        end

        quiet();
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
